// File: rtl/uart_rx_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_pkg                                                    |
// | Brief  : Register map, register bit positions and receiver states.   |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
package uart_pkg;

  localparam logic [1:0] REG_DATA   = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_CTRL   = 2'd2;
  localparam logic [1:0] REG_RSVD   = 2'd3;

  localparam int ST_NEMPTY  = 0;
  localparam int ST_FULL    = 1;
  localparam int ST_OVR     = 2;
  localparam int ST_FRM     = 3;
  localparam int ST_CNT_LSB = 4;

  localparam int CT_IE_RX  = 0;
  localparam int CT_IE_ERR = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } rx_state_e;

endpackage
`default_nettype wire

// File: rtl/uart_rx_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_rx_if                                                  |
// | Brief  : Wishbone-style data bus between a master and the receiver.  |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
interface uart_rx_if;
  logic [31:0] wb_dbus_adr;
  logic [31:0] wb_dbus_dat;
  logic [3:0]  wb_dbus_sel;
  logic        wb_dbus_we;
  logic        wb_dbus_cyc;
  logic [31:0] rdt;
  logic        ack;

  modport master (
    output wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
    input  rdt, ack
  );

  modport slave (
    input  wb_dbus_adr, wb_dbus_dat, wb_dbus_sel, wb_dbus_we, wb_dbus_cyc,
    output rdt, ack
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : rx_fifo                                                     |
// | Brief  : Synchronous byte FIFO with occupancy count and flags.       |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module rx_fifo #(
  parameter int DEPTH = 16
) (
  input  wire logic                     clk,
  input  wire logic                     rst,
  input  wire logic                     push,
  input  wire logic [7:0]               din,
  input  wire logic                     pop,
  output logic      [7:0]               dout,
  output logic      [$clog2(DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);
  localparam int AW = $clog2(DEPTH);

  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          wr_en;
  logic          rd_en;

  assign full  = (count == (AW+1)'(DEPTH));
  assign empty = (count == '0);
  // A pop frees the slot in the same cycle, so a full FIFO still accepts a push.
  assign wr_en = push && (!full || pop);
  assign rd_en = pop && !empty;
  assign dout  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + (AW+1)'(wr_en) - (AW+1)'(rd_en);
    end
  end
endmodule
`default_nettype wire

// File: rtl/uart_rx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : uart_rx                                                     |
// | Brief  : 8N1 UART receiver with 16x oversampling, FIFO and bus regs. |
// | Rev    : 1.0  initial release                                        |
// +----------------------------------------------------------------------+
module uart_rx
  import uart_pkg::*;
#(
  parameter int               AWIDTH     = 8,
  parameter logic [AWIDTH-1:0] ADDR      = 8'h58,
  parameter int               CK_HZ      = 26250000,
  parameter int               BAUD       = 115200,
  parameter int               FIFO_DEPTH = 16
) (
  input  wire logic   wb_clk,
  input  wire logic   wb_rst,
  uart_rx_if.slave    dbus,
  input  wire logic   rx,
  output logic        irq
);
  localparam int DIVIDE = CK_HZ / (BAUD * 16);
  localparam int DIV_W  = $clog2(DIVIDE + 1);
  localparam int CW     = $clog2(FIFO_DEPTH) + 1;

  logic             rx_meta, rx_sync, rx_prev;
  logic [DIV_W-1:0] baud_cnt;
  logic             tick;
  rx_state_e        state, state_nxt;
  logic [3:0]       os_cnt, os_nxt;
  logic [2:0]       bit_idx, bit_nxt;
  logic [7:0]       shreg, sh_nxt;
  logic             enter_start, push, frm_set, ovr_set;
  logic             sel, busy, ack_r, rd_access, wr_access, pop;
  logic [1:0]       reg_sel;
  logic [1:0]       ctrl;
  logic             ovr, frm;
  logic [7:0]       fifo_dout;
  logic [CW-1:0]    fifo_count;
  logic             fifo_full, fifo_empty;
  logic [31:0]      rdt_mux;
  logic             unused_bus;

  assign unused_bus = ^{dbus.wb_dbus_sel, dbus.wb_dbus_dat[31:4],
                        dbus.wb_dbus_adr[31-AWIDTH:4], dbus.wb_dbus_adr[1:0]};

  // Synchroniser resets low so a line held low out of reset never looks like a start edge.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      rx_meta <= 1'b0;
      rx_sync <= 1'b0;
      rx_prev <= 1'b0;
    end else begin
      rx_meta <= rx;
      rx_sync <= rx_meta;
      rx_prev <= rx_sync;
    end
  end

  assign tick = (baud_cnt == DIV_W'(DIVIDE - 1));

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst)                    baud_cnt <= '0;
    else if (enter_start || tick)  baud_cnt <= '0;
    else                           baud_cnt <= baud_cnt + 1'b1;
  end

  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      state   <= S_IDLE;
      os_cnt  <= '0;
      bit_idx <= '0;
      shreg   <= '0;
    end else begin
      state   <= state_nxt;
      os_cnt  <= os_nxt;
      bit_idx <= bit_nxt;
      shreg   <= sh_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    os_nxt      = os_cnt;
    bit_nxt     = bit_idx;
    sh_nxt      = shreg;
    enter_start = 1'b0;
    push        = 1'b0;
    frm_set     = 1'b0;
    case (state)
      S_IDLE: begin
        if (rx_prev && !rx_sync) begin
          state_nxt   = S_START;
          os_nxt      = '0;
          enter_start = 1'b1;
        end
      end
      S_START: begin
        if (tick) begin
          os_nxt = os_cnt + 1'b1;
          if (os_cnt == 4'd7) begin
            os_nxt    = '0;
            bit_nxt   = '0;
            state_nxt = rx_sync ? S_IDLE : S_DATA;
          end
        end
      end
      S_DATA: begin
        if (tick) begin
          os_nxt = os_cnt + 1'b1;
          if (os_cnt == 4'd15) begin
            sh_nxt  = {rx_sync, shreg[7:1]};
            bit_nxt = bit_idx + 1'b1;
            if (bit_idx == 3'd7) state_nxt = S_STOP;
          end
        end
      end
      S_STOP: begin
        if (tick) begin
          os_nxt = os_cnt + 1'b1;
          if (os_cnt == 4'd15) begin
            state_nxt = S_IDLE;
            push      = rx_sync;
            frm_set   = !rx_sync;
          end
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  rx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (wb_clk),
    .rst   (wb_rst),
    .push  (push),
    .din   (shreg),
    .pop   (pop),
    .dout  (fifo_dout),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  assign sel       = dbus.wb_dbus_cyc && (dbus.wb_dbus_adr[31 -: AWIDTH] == ADDR);
  assign reg_sel   = dbus.wb_dbus_adr[3:2];
  assign rd_access = ack_r && !dbus.wb_dbus_we;
  assign wr_access = ack_r && dbus.wb_dbus_we;
  assign pop       = rd_access && (reg_sel == REG_DATA) && !fifo_empty;
  assign ovr_set   = push && fifo_full && !pop;

  // busy holds off a second ack until the master drops cyc.
  always_ff @(posedge wb_clk or posedge wb_rst) begin
    if (wb_rst) begin
      ack_r <= 1'b0;
      busy  <= 1'b0;
      ctrl  <= '0;
      ovr   <= 1'b0;
      frm   <= 1'b0;
      irq   <= 1'b0;
    end else begin
      ack_r <= sel && !ack_r && !busy;
      busy  <= dbus.wb_dbus_cyc && (busy || ack_r);
      if (wr_access && reg_sel == REG_CTRL) ctrl <= dbus.wb_dbus_dat[1:0];
      if (ovr_set)                                                        ovr <= 1'b1;
      else if (wr_access && reg_sel == REG_STATUS && dbus.wb_dbus_dat[ST_OVR]) ovr <= 1'b0;
      if (frm_set)                                                        frm <= 1'b1;
      else if (wr_access && reg_sel == REG_STATUS && dbus.wb_dbus_dat[ST_FRM]) frm <= 1'b0;
      irq <= (ctrl[CT_IE_RX] && !fifo_empty) || (ctrl[CT_IE_ERR] && (ovr || frm));
    end
  end

  always_comb begin
    rdt_mux = '0;
    case (reg_sel)
      REG_DATA: begin
        if (!fifo_empty) rdt_mux[8:0] = {1'b1, fifo_dout};
      end
      REG_STATUS: begin
        rdt_mux[ST_NEMPTY]         = !fifo_empty;
        rdt_mux[ST_FULL]           = fifo_full;
        rdt_mux[ST_OVR]            = ovr;
        rdt_mux[ST_FRM]            = frm;
        rdt_mux[ST_CNT_LSB +: 5]   = 5'(fifo_count);
      end
      REG_CTRL: rdt_mux[1:0] = ctrl;
      default:  rdt_mux = '0;
    endcase
  end

  assign dbus.ack = ack_r;
  assign dbus.rdt = ack_r ? rdt_mux : '0;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// Directed bench for uart_rx: bus register access and serial frames at 115200 baud
// on a 26.25 MHz clock (14 clocks per oversample tick, 224 per bit).
module tb_uart_rx;
  localparam int DIVIDE = 14;
  localparam int BIT    = DIVIDE * 16;

  logic wb_clk = 1'b0;
  logic wb_rst;
  logic rx;
  logic irq;
  int   vectors     = 0;
  int   miscompares = 0;

  uart_rx_if bus ();

  uart_rx dut (
    .wb_clk (wb_clk),
    .wb_rst (wb_rst),
    .dbus   (bus),
    .rx     (rx),
    .irq    (irq)
  );

  always #5 wb_clk = ~wb_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic bus_xfer(input logic we, input logic [3:0] off, input logic [31:0] wdata,
                          output logic [31:0] rdata);
    int n;
    rdata = '0;
    @(negedge wb_clk);
    bus.wb_dbus_adr = {8'h58, 20'h0, off};
    bus.wb_dbus_dat = wdata;
    bus.wb_dbus_we  = we;
    bus.wb_dbus_sel = 4'hf;
    bus.wb_dbus_cyc = 1'b1;
    n = 0;
    do begin
      @(negedge wb_clk);
      n++;
    end while (!bus.ack && n < 16);
    check("ack_seen", {31'd0, bus.ack}, 32'd1);
    rdata = bus.rdt;
    @(negedge wb_clk);
    check("ack_single", {31'd0, bus.ack}, 32'd0);
    bus.wb_dbus_cyc = 1'b0;
    bus.wb_dbus_we  = 1'b0;
  endtask

  task automatic reg_read(input string tag, input logic [3:0] off, input logic [31:0] exp);
    logic [31:0] r;
    bus_xfer(1'b0, off, 32'd0, r);
    check(tag, r, exp);
  endtask

  task automatic reg_write(input logic [3:0] off, input logic [31:0] val);
    logic [31:0] r;
    bus_xfer(1'b1, off, val, r);
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
    rx = 1'b0;
    repeat (BIT) @(negedge wb_clk);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      repeat (BIT) @(negedge wb_clk);
    end
    rx = stop;
    repeat (BIT) @(negedge wb_clk);
    rx = 1'b1;
    repeat (BIT / 4) @(negedge wb_clk);
  endtask

  initial begin
    logic seen_ack;
    wb_rst          = 1'b1;
    rx              = 1'b1;
    bus.wb_dbus_adr = '0;
    bus.wb_dbus_dat = '0;
    bus.wb_dbus_sel = '0;
    bus.wb_dbus_we  = 1'b0;
    bus.wb_dbus_cyc = 1'b0;

    // Reset state
    repeat (4) @(negedge wb_clk);
    check("rst_ack", {31'd0, bus.ack}, 32'd0);
    check("rst_rdt", bus.rdt, 32'd0);
    check("rst_irq", {31'd0, irq}, 32'd0);
    wb_rst = 1'b0;
    repeat (5) @(negedge wb_clk);
    check("post_rst_ack", {31'd0, bus.ack}, 32'd0);
    check("post_rst_rdt", bus.rdt, 32'd0);
    check("post_rst_irq", {31'd0, irq}, 32'd0);
    reg_read("status_reset", 4'h4, 32'h000);

    // Single byte
    send_frame(8'hA5, 1'b1);
    reg_read("status_a5", 4'h4, 32'h011);
    reg_read("data_a5", 4'h0, 32'h1A5);
    reg_read("status_after_pop", 4'h4, 32'h000);
    reg_read("data_empty", 4'h0, 32'h000);

    // Fill past capacity: count 16 + full + overrun, and not-empty is also set
    for (int i = 0; i < 17; i++) send_frame(8'(i), 1'b1);
    reg_read("status_overrun", 4'h4, 32'h107);
    for (int i = 0; i < 16; i++) reg_read("data_fifo", 4'h0, 32'h100 + 32'(i));
    reg_write(4'h4, 32'h4);
    reg_read("status_ovr_clr", 4'h4, 32'h000);

    // Framing error and error interrupt
    send_frame(8'h55, 1'b0);
    reg_read("status_framing", 4'h4, 32'h008);
    reg_write(4'h8, 32'h2);
    reg_read("ctrl_rb", 4'h8, 32'h2);
    repeat (2) @(negedge wb_clk);
    check("irq_err_on", {31'd0, irq}, 32'd1);
    reg_write(4'h4, 32'h8);
    repeat (2) @(negedge wb_clk);
    check("irq_err_off", {31'd0, irq}, 32'd0);
    reg_read("status_frm_clr", 4'h4, 32'h000);
    reg_write(4'h8, 32'h0);

    // Glitch shorter than half a bit is rejected
    rx = 1'b0;
    repeat (4 * DIVIDE) @(negedge wb_clk);
    rx = 1'b1;
    repeat (2 * BIT) @(negedge wb_clk);
    reg_read("status_glitch", 4'h4, 32'h000);
    reg_write(4'h8, 32'h1);
    repeat (2) @(negedge wb_clk);
    check("irq_rx_empty", {31'd0, irq}, 32'd0);
    send_frame(8'h3C, 1'b1);
    check("irq_rx_on", {31'd0, irq}, 32'd1);
    reg_read("data_3c", 4'h0, 32'h13C);
    repeat (2) @(negedge wb_clk);
    check("irq_rx_off", {31'd0, irq}, 32'd0);

    // Unselected device address never acks; reserved offset and DATA writes are inert
    @(negedge wb_clk);
    bus.wb_dbus_adr = 32'h4000_0000;
    bus.wb_dbus_cyc = 1'b1;
    seen_ack = 1'b0;
    repeat (8) begin
      @(negedge wb_clk);
      seen_ack = seen_ack | bus.ack;
    end
    bus.wb_dbus_cyc = 1'b0;
    check("nosel_ack", {31'd0, seen_ack}, 32'd0);
    reg_read("rsvd_read", 4'hC, 32'h000);
    reg_write(4'hC, 32'hFFFF_FFFF);
    reg_write(4'h0, 32'h0000_005A);
    reg_read("status_after_ign", 4'h4, 32'h000);

    // Reset in the middle of data bit 4 with the line held low
    reg_write(4'h8, 32'h3);
    rx = 1'b0;
    repeat (5 * BIT + BIT / 2) @(negedge wb_clk);
    wb_rst = 1'b1;
    repeat (3) @(negedge wb_clk);
    check("midrst_irq", {31'd0, irq}, 32'd0);
    wb_rst = 1'b0;
    repeat (12 * BIT) @(negedge wb_clk);
    reg_read("status_midrst", 4'h4, 32'h000);
    reg_read("ctrl_midrst", 4'h8, 32'h000);
    rx = 1'b1;
    repeat (BIT) @(negedge wb_clk);
    send_frame(8'h81, 1'b1);
    reg_read("data_81", 4'h0, 32'h181);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
`default_nettype wire
